// File: rtl/regwrite_arb_pkg.sv
// Shared types for the register-file write-port arbiter: grant sources, default widths, I/O request.
// Latency: n/a (types only).
// Backpressure: n/a.
package regwrite_arb_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_IO   = 2'd2
    } gnt_src_e;

    typedef struct packed {
        logic [AW_DEF-1:0] wa;
        logic [DW_DEF-1:0] wd;
    } io_req_t;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Bundles the CPU writeback, I/O request and regfile write-port signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: io_valid/io_ready handshake on the I/O side, cpu_stall on the CPU side.
interface regwrite_arbiter_if #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cpu_we;
    logic [AW-1:0] cpu_wa;
    logic [DW-1:0] cpu_wd;
    logic          cpu_stall;
    logic          io_valid;
    logic          io_ready;
    logic [AW-1:0] io_wa;
    logic [DW-1:0] io_wd;
    logic          rf_we3;
    logic [AW-1:0] rf_wa3;
    logic [DW-1:0] rf_wd3;
    logic [CW-1:0] pend_cnt;
    logic          busy;

    modport master (
        output cpu_we, cpu_wa, cpu_wd, io_valid, io_wa, io_wd,
        input  cpu_stall, io_ready, rf_we3, rf_wa3, rf_wd3, pend_cnt, busy
    );

    modport slave (
        input  cpu_we, cpu_wa, cpu_wd, io_valid, io_wa, io_wd,
        output cpu_stall, io_ready, rf_we3, rf_wa3, rf_wd3, pend_cnt, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (power of 2).
// Latency: a pushed entry is visible at dout one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the regfile write port between CPU writeback (priority) and queued I/O writes; REGWRITE_ARB_BYPASS_EN adds an empty-FIFO bypass.
// Latency: I/O write reaches regfile >=1 edge after acceptance (0 with bypass); forced grant after MAX_WAIT denials.
// Backpressure: io_ready = !full; CPU is stalled only on a forced I/O grant.
module regwrite_arbiter
    import regwrite_arb_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    regwrite_arbiter_if.slave bus
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } req_t;

    req_t           head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  cnt;
    logic           fifo_push;
    logic           fifo_pop;
    logic           force_io;
    logic           bypass;
    logic           stall;
    gnt_src_e       gnt;
    logic [WCW-1:0] wait_cnt;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.io_wa, bus.io_wd}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    assign force_io = (wait_cnt == WCW'(MAX_WAIT)) && !empty;

    // Reset masks every grant so nothing half-written escapes while the queue is flushed.
    always_comb begin
        gnt    = GNT_NONE;
        bypass = 1'b0;
        stall  = 1'b0;
        if (!reset) begin
            if (force_io) begin
                gnt   = GNT_IO;
                stall = bus.cpu_we;
            end else if (bus.cpu_we) begin
                gnt = GNT_CPU;
            end else if (!empty) begin
                gnt = GNT_IO;
`ifdef REGWRITE_ARB_BYPASS_EN
            end else if (bus.io_valid) begin
                gnt    = GNT_IO;
                bypass = 1'b1;
`endif
            end
        end
    end

    assign fifo_pop      = (gnt == GNT_IO) && !bypass;
    assign bus.io_ready  = !reset && !full;
    assign fifo_push     = bus.io_valid && bus.io_ready && !bypass;
    assign bus.cpu_stall = stall;
    assign bus.rf_we3    = (gnt != GNT_NONE);
    assign bus.rf_wa3    = (gnt != GNT_IO) ? bus.cpu_wa : (bypass ? bus.io_wa : head.wa);
    assign bus.rf_wd3    = (gnt != GNT_IO) ? bus.cpu_wd : (bypass ? bus.io_wd : head.wd);
    assign bus.pend_cnt  = cnt;
    assign bus.busy      = (cnt != '0);

    // Counts consecutive cycles the queue head has been passed over; saturates at the force threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (empty || fifo_pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WCW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Randomized + directed bench for regwrite_arbiter: a queue-based reference model predicts each cycle's
// outputs into a scoreboard that a negedge monitor pops and compares against the DUT.
module tb_regwrite_arbiter;
    import regwrite_arb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       stall;
        logic       rdy;
        logic       busy;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regwrite_arbiter_if #(.DW(8), .AW(4), .DEPTH(DEPTH)) bus ();

    regwrite_arbiter #(.DW(8), .AW(4), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending I/O writes in arrival order, and how long the oldest one has been passed over.
    io_req_t pend[$];
    int      head_age = 0;
    bit      m_stall  = 0;
    bit      m_acc    = 0;
    exp_t    expq[$];

    logic [7:0] dut_rf [16];
    int         disc_seen = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void model_eval();
        exp_t    e;
        io_req_t r;
        int      n = pend.size();
        bit      full = (n == DEPTH);
        bit      head_gnt = 0;
        bit      byp = 0;
        e.cnt = n; e.busy = (n != 0);
        e.we = 0; e.wa = 0; e.wd = 0; e.stall = 0; e.rdy = 0;
        if (reset) begin
            pend.delete();
            head_age = 0; m_stall = 0; m_acc = 0;
        end else begin
            e.rdy = !full;
            if (n > 0 && head_age >= MAX_WAIT) begin
                head_gnt = 1; e.stall = bus.cpu_we;
            end else if (bus.cpu_we) begin
                e.we = 1; e.wa = bus.cpu_wa; e.wd = bus.cpu_wd;
            end else if (n > 0) begin
                head_gnt = 1;
`ifdef REGWRITE_ARB_BYPASS_EN
            end else if (bus.io_valid) begin
                byp = 1; e.we = 1; e.wa = bus.io_wa; e.wd = bus.io_wd;
`endif
            end
            if (head_gnt) begin
                e.we = 1; e.wa = pend[0].wa; e.wd = pend[0].wd;
            end
            m_acc = bus.io_valid && (byp || !full);
            if (n == 0 || head_gnt) head_age = 0;
            else if (head_age < MAX_WAIT) head_age++;
            if (head_gnt) void'(pend.pop_front());
            if (bus.io_valid && !full && !byp) begin
                r.wa = bus.io_wa; r.wd = bus.io_wd;
                pend.push_back(r);
            end
            m_stall = e.stall;
        end
        expq.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rf_we3", int'(bus.rf_we3), int'(e.we));
            if (e.we) begin
                chk("rf_wa3", int'(bus.rf_wa3), int'(e.wa));
                chk("rf_wd3", int'(bus.rf_wd3), int'(e.wd));
            end
            chk("cpu_stall", int'(bus.cpu_stall), int'(e.stall));
            chk("io_ready", int'(bus.io_ready), int'(e.rdy));
            chk("pend_cnt", int'(bus.pend_cnt), e.cnt);
            chk("busy", int'(bus.busy), int'(e.busy));
        end
        if (bus.rf_we3 === 1'b1) begin
            dut_rf[bus.rf_wa3] = bus.rf_wd3;
            if (bus.rf_wd3 inside {8'hE0, 8'hE1, 8'hE2}) disc_seen++;
        end
    end

    task automatic cyc(input logic rst, input logic cwe, input logic [3:0] cwa, input logic [7:0] cwd,
                       input logic iv, input logic [3:0] iwa, input logic [7:0] iwd);
        reset = rst;
        bus.cpu_we = cwe; bus.cpu_wa = cwa; bus.cpu_wd = cwd;
        bus.io_valid = iv; bus.io_wa = iwa; bus.io_wd = iwd;
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pend.size() > 0; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain_empty", pend.size(), 0);
    endtask

    initial begin
        logic       cwe, iv, rst;
        logic [3:0] cwa, iwa;
        logic [7:0] cwd, iwd;
        int         k;
        for (int i = 0; i < 16; i++) dut_rf[i] = 8'h00;
        reset = 1'b1;
        bus.cpu_we = 0; bus.cpu_wa = 0; bus.cpu_wd = 0;
        bus.io_valid = 0; bus.io_wa = 0; bus.io_wd = 0;
        @(posedge clk);
        #1;

        // Reset held with an I/O request pending, then release.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 4'd9, 8'h99);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Idle CPU, single I/O write.
        cyc(0, 0, 0, 0, 1, 4'd5, 8'h3C);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);

        // Continuous CPU writes starve one queued I/O write until it is forced.
        cyc(0, 1, 4'd2, 8'h20, 1, 4'd7, 8'hA5);
        for (int i = 1; i < 8; i++) cyc(0, 1, 4'd2, 8'(8'h20 + (m_stall ? i - 1 : i)), 0, 0, 0);

        // Fill the FIFO under continuous CPU load; the fifth write waits for space.
        k = 1;
        for (int c = 0; c < 30; c++) begin
            cyc(0, 1, 4'd2, 8'h40, k <= 5, 4'(k), 8'(8'h10 + k));
            if (m_acc) k++;
        end
        chk("all_five_accepted", k, 6);
        drain();

        // Same-register collision: CPU granted first, queued I/O write lands last.
        cyc(0, 1, 4'd3, 8'h22, 1, 4'd3, 8'h11);
        drain();
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("r3_final", int'(dut_rf[3]), 8'h11);

        // Reset with three queued writes: they must never reach the regfile.
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'd1, 8'h55, 1, 4'(10 + i), 8'(8'hE0 + i));
        chk("pend_before_reset", pend.size(), 3);
        cyc(1, 1, 4'd1, 8'h55, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, i < 4, 4'd1, 8'h55, 0, 0, 0);
        chk("reset_discard", disc_seen, 0);

        // Random traffic with held requests and occasional resets.
        cwe = 0; cwa = 0; cwd = 0; iv = 0; iwa = 0; iwd = 0;
        for (int c = 0; c < 600; c++) begin
            if (!m_stall) begin
                cwe = ($urandom_range(0, 99) < 60);
                cwa = 4'($urandom_range(0, 15));
                cwd = 8'($urandom_range(0, 255));
            end
            if (!iv || m_acc) begin
                iv  = ($urandom_range(0, 99) < 45);
                iwa = 4'($urandom_range(0, 15));
                iwd = 8'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 199) == 0);
            cyc(rst, cwe, cwa, cwd, iv, iwa, iwd);
        end
        drain();
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_left", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
